// File: rtl/map_render_ctrl_if.sv
// Pixel-plot and map-drawer handshake bundle for map_render_ctrl.
// slave is the controller side, master the driver/observer side.
interface map_render_ctrl_if;
    logic       start;
    logic [1:0] map_sel_in;
    logic [7:0] mx;
    logic [6:0] my;
    logic       map_finish;
    logic       map_counter_enable;
    logic [1:0] mapselect;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport slave (
        input  start, map_sel_in, mx, my, map_finish,
        output map_counter_enable, mapselect, x, y, colour,
        output plot, busy, done
    );

    modport master (
        output start, map_sel_in, mx, my, map_finish,
        input  map_counter_enable, mapselect, x, y, colour,
        input  plot, busy, done
    );
endinterface

// File: rtl/map_render_ctrl.sv
// Render sequencer: clears the screen one pixel per cycle, then forwards
// map tile pixels until the drawer flags its last tile.
module map_render_ctrl #(
    parameter int       SCREEN_W    = 160,
    parameter int       SCREEN_H    = 120,
    parameter bit [2:0] BG_COLOUR   = 3'b000,
    parameter bit [2:0] WALL_COLOUR = 3'b110
) (
    input logic             clk,
    input logic             reset,
    map_render_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        MAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CX_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] CY_LAST = 7'(SCREEN_H - 1);

    state_t     r_state;
    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic [1:0] r_mapsel;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_done;
    logic       w_busy;
    logic       w_map_en;

    assign w_busy   = (r_state == CLEAR) || (r_state == MAP);
    assign w_map_en = (r_state == MAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cx     <= '0;
            r_cy     <= '0;
            r_mapsel <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mapsel <= bus.map_sel_in;
                        r_cx     <= '0;
                        r_cy     <= '0;
                        r_state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_x      <= r_cx;
                    r_y      <= r_cy;
                    r_colour <= BG_COLOUR;
                    r_plot   <= 1'b1;
                    if (r_cx == CX_LAST) begin
                        r_cx <= '0;
                        if (r_cy == CY_LAST) begin
                            r_cy    <= '0;
                            r_state <= MAP;
                        end else begin
                            r_cy <= r_cy + 7'd1;
                        end
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                MAP: begin
                    // The finishing tile is still plotted before leaving MAP
                    r_x      <= bus.mx;
                    r_y      <= bus.my;
                    r_colour <= WALL_COLOUR;
                    r_plot   <= 1'b1;
                    if (bus.map_finish) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.map_counter_enable = w_map_en;
    assign bus.mapselect          = r_mapsel;
    assign bus.x                  = r_x;
    assign bus.y                  = r_y;
    assign bus.colour             = r_colour;
    assign bus.plot               = r_plot;
    assign bus.busy               = w_busy;
    assign bus.done               = r_done;
endmodule

// File: tb/tb_map_render_ctrl.sv
// Scoreboard bench for map_render_ctrl: expected plots are queued by the
// stimulus and popped by a negedge monitor whenever plot is high.
module tb_map_render_ctrl;
    localparam int W = 160;
    localparam int H = 120;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];

    map_render_ctrl_if m ();

    map_render_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        pix_t e;
        pix_t a;
        if (m.plot === 1'b1) begin
            a = '{x: m.x, y: m.y, c: m.colour};
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL plot_unexpected: got %h expected no plot", a);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL plot_pix: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                             a.x, a.y, a.c, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                sb.push_back('{x: 8'(xx), y: 7'(yy), c: 3'b000});
    endtask

    task automatic wait_map(input string name);
        int n;
        n = 0;
        while (m.map_counter_enable !== 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        chk({name, "_map_reached"}, int'(m.map_counter_enable === 1'b1), 1);
    endtask

    // Drive k map pixels, last one with map_finish; then check the tail.
    task automatic run_map(input string name, input int k, input int base);
        for (int i = 0; i < k; i++) begin
            chk({name, "_mce"}, int'(m.map_counter_enable), 1);
            m.mx = 8'(base + 3 * i);
            m.my = 7'(base + 7 * i + 1);
            m.map_finish = (i == k - 1);
            sb.push_back('{x: m.mx, y: m.my, c: 3'b110});
            tick();
        end
        m.map_finish = 1'b0;
        chk({name, "_done_mce_lo"}, int'(m.map_counter_enable), 0);
        chk({name, "_done_busy_lo"}, int'(m.busy), 0);
        chk({name, "_done_early"}, int'(m.done), 0);
    endtask

    initial begin
        reset        = 1'b1;
        m.start      = 1'b0;
        m.map_sel_in = 2'd0;
        m.mx         = 8'd0;
        m.my         = 7'd0;
        m.map_finish = 1'b0;
        repeat (3) tick();
        chk("rst_plot", int'(m.plot), 0);
        chk("rst_busy", int'(m.busy), 0);
        chk("rst_done", int'(m.done), 0);
        chk("rst_mce", int'(m.map_counter_enable), 0);
        chk("rst_msel", int'(m.mapselect), 0);
        chk("rst_xyc", int'({m.x, m.y, m.colour}), 0);
        reset = 1'b0;
        tick();

        // Render 1: map 2, start glitch during clear
        m.start      = 1'b1;
        m.map_sel_in = 2'd2;
        push_clear();
        tick();
        m.start = 1'b0;
        chk("r1_msel", int'(m.mapselect), 2);
        chk("r1_busy", int'(m.busy), 1);
        chk("r1_mce_clear", int'(m.map_counter_enable), 0);
        repeat (100) tick();
        m.start      = 1'b1;
        m.map_sel_in = 2'd1;
        repeat (5) tick();
        m.start = 1'b0;
        chk("r1_msel_hold", int'(m.mapselect), 2);
        chk("r1_busy_clear", int'(m.busy), 1);
        wait_map("r1");
        run_map("r1", 4, 20);
        tick();
        chk("r1_done", int'(m.done), 1);
        chk("r1_busy_idle", int'(m.busy), 0);
        tick();
        chk("r1_done_once", int'(m.done), 0);
        chk("r1_q_empty", sb.size(), 0);

        // Reset while clear is at cx=50
        m.start      = 1'b1;
        m.map_sel_in = 2'd1;
        push_clear();
        tick();
        m.start = 1'b0;
        chk("rs_msel", int'(m.mapselect), 1);
        repeat (50) tick();
        reset = 1'b1;
        tick();
        sb.delete();
        reset = 1'b0;
        chk("rs_plot", int'(m.plot), 0);
        chk("rs_busy", int'(m.busy), 0);
        chk("rs_mce", int'(m.map_counter_enable), 0);
        chk("rs_msel", int'(m.mapselect), 0);
        tick();
        chk("rs_plot_idle", int'(m.plot), 0);

        // Start held high: two back-to-back renders of map 3
        m.start      = 1'b1;
        m.map_sel_in = 2'd3;
        push_clear();
        tick();
        chk("h1_msel", int'(m.mapselect), 3);
        chk("h1_busy", int'(m.busy), 1);
        wait_map("h1");
        run_map("h1", 3, 90);
        push_clear();
        tick();
        chk("h1_done", int'(m.done), 1);
        chk("h1_idle_busy", int'(m.busy), 0);
        tick();
        chk("h2_busy", int'(m.busy), 1);
        chk("h2_done_once", int'(m.done), 0);
        m.start = 1'b0;
        wait_map("h2");
        run_map("h2", 2, 5);
        tick();
        chk("h2_done", int'(m.done), 1);
        tick();
        tick();
        chk("h2_idle_busy", int'(m.busy), 0);
        chk("end_q_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/map_render_ctrl.md
MAP_RENDER_CTRL -- requirements
Module: map_render_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, visible pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 120, visible pixel rows.
REQ-003 SHALL have parameter BG_COLOUR, default 3'b000, colour written during screen clear.
REQ-004 SHALL have parameter WALL_COLOUR, default 3'b110, colour written for map pixels.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request a full render (clear, then map draw).
REQ-008 SHALL have port map_sel_in  input  2  map number to render; sampled on an accepted start.
REQ-009 SHALL have port mx  input  8  map pixel x from the map tile drawer.
REQ-010 SHALL have port my  input  7  map pixel y from the map tile drawer.
REQ-011 SHALL have port map_finish  input  1  map tile drawer last-tile flag.
REQ-012 SHALL have port map_counter_enable  output  1  run enable to the map tile drawer.
REQ-013 SHALL have port mapselect  output  2  latched map number to the map tile drawer.
REQ-014 SHALL have port x  output  8  VGA adapter pixel x.
REQ-015 SHALL have port y  output  7  VGA adapter pixel y.
REQ-016 SHALL have port colour  output  3  VGA adapter pixel colour.
REQ-017 SHALL have port plot  output  1  VGA adapter write strobe.
REQ-018 SHALL have port busy  output  1  high in CLEAR and MAP.
REQ-019 SHALL have port done  output  1  one-cycle pulse at end of render.

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, MAP, DONE.
REQ-021 SHALL, in IDLE with start=1, latch map_sel_in into mapselect, zero the clear counters cx and cy, and enter CLEAR next cycle.
REQ-022 SHALL ignore start in CLEAR, MAP and DONE; mapselect SHALL not change outside an accepted start.
REQ-023 SHALL, in CLEAR, step cx 0..SCREEN_W-1 each cycle; on wrap, set cx=0 and increment cy; on (SCREEN_W-1, SCREEN_H-1), enter MAP next cycle; one pixel per cycle, SCREEN_W*SCREEN_H cycles total (19200 at defaults).
REQ-024 SHALL drive map_counter_enable=1 combinationally in state MAP only, else 0.
REQ-025 SHALL, in MAP, forward mx/my as the pixel coordinate with WALL_COLOUR every cycle, including the cycle in which map_finish=1.
REQ-026 SHALL, in MAP with map_finish=1, enter DONE next cycle; map_counter_enable SHALL therefore fall one cycle after map_finish is sampled high.
REQ-027 SHALL, in DONE, assert done for exactly one cycle and return to IDLE next cycle; start in DONE is not accepted.
REQ-028 SHALL register x, y, colour, plot: the values they carry in cycle N+1 come from the state and counters (CLEAR) or mx/my (MAP) in cycle N; plot(N+1)=1 iff state(N) is CLEAR or MAP.
REQ-029 SHALL keep x, y, colour holding their last values when plot=0.
REQ-030 SHALL drive busy combinationally from the current state (CLEAR or MAP).
REQ-031 SHALL truncate nothing: cx fits 8 bits, cy fits 7 bits for the default parameters; mx/my pass through unmodified.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, enter IDLE; state, cx, cy, mapselect, x, y, colour reset to 0; plot, done reset to 0; busy and map_counter_enable therefore 0 from that edge.
REQ-033 SHALL give reset priority over start and map_finish, including reset mid-CLEAR or mid-MAP; no further plot after the reset edge.

Verification
REQ-034 Reset, then start=1 with map_sel_in=2 -> mapselect=2, busy=1 next cycle; first plot is x=0, y=0, colour=000.
REQ-035 Full clear -> exactly 19200 consecutive plot cycles with BG_COLOUR; the last is x=159, y=119; the next plot cycle carries mx/my with colour=110.
REQ-036 In MAP, pulse map_finish for one cycle -> that cycle's mx/my plotted; map_counter_enable low the next cycle; done high one cycle after that, then busy=0.
REQ-037 Assert start during CLEAR with map_sel_in=1 -> mapselect unchanged, cx/cy sequence undisturbed.
REQ-038 Assert reset at cx=50 in CLEAR -> next cycle state IDLE, plot=0, busy=0, map_counter_enable=0; a new start restarts at (0,0).
REQ-039 Hold start=1 continuously -> a render, a one-cycle done, one IDLE cycle, then a new render accepted.
